// File: rtl/seg7_if.sv
`default_nettype none
// seg7_if: datapath-to-display bundle for seg7_scan_driver (digit codes in, display pins out).
// Revision: 1.0
interface seg7_if #(
  parameter int NUM_DIGITS = 8
);
  logic                    en;
  logic [4*NUM_DIGITS-1:0] data;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   digit_mask;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_tick;

  modport master (
    output en, data, dp_in, digit_mask,
    input  seg, dp, an, frame_tick
  );

  modport slave (
    input  en, data, dp_in, digit_mask,
    output seg, dp, an, frame_tick
  );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// seg7_scan_driver: frame-buffered, blank-windowed multiplexer for an N-digit common-anode display.
// Optional SEG7_LEADING_ZERO_BLANK_EN hides leading zeros at frame load. Revision: 1.0
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 8
) (
  input  wire logic clk,
  input  wire logic rst_n,
  seg7_if.slave     bus
);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_MAX   = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PRESC_BLANK = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_MAX     = IW'(NUM_DIGITS - 1);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t                state, state_next;
  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic [3:0]            sh_data [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] sh_dp;
  logic [NUM_DIGITS-1:0] sh_mask;
  logic [NUM_DIGITS-1:0] load_mask;
  logic                  en;
  logic                  load;
  logic                  slot_end;
  logic                  frame_end;
  logic                  lit;
  logic [6:0]            seg_q;
  logic                  dp_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic                  tick_q;

  assign en             = bus.en;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_tick = tick_q;

  function automatic logic [6:0] glyph(input logic [3:0] code);
    case (code)
      4'h0:    glyph = 7'b0000001;
      4'h1:    glyph = 7'b1001111;
      4'h2:    glyph = 7'b0010010;
      4'h3:    glyph = 7'b0000110;
      4'h4:    glyph = 7'b1001100;
      4'h5:    glyph = 7'b0100100;
      4'h6:    glyph = 7'b0100000;
      4'h7:    glyph = 7'b0001111;
      4'h8:    glyph = 7'b0000000;
      4'h9:    glyph = 7'b0001100;
      4'hA:    glyph = 7'b0001000;
      4'hB:    glyph = 7'b0011000;
      default: glyph = 7'b1111111;
    endcase
  endfunction

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // Walk from the top digit down; once a nonzero code or a lit dp is seen, everything below stays visible.
  always_comb begin
    logic seen;
    seen      = 1'b0;
    load_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      seen         = seen | (bus.data[4*i +: 4] != 4'h0) | bus.dp_in[i];
      load_mask[i] = bus.digit_mask[i] & (seen | (i == 0));
    end
  end
`else
  assign load_mask = bus.digit_mask;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    slot_end   = (presc == PRESC_MAX);
    frame_end  = slot_end && (idx == IDX_MAX);
    case (state)
      IDLE: begin
        if (en) begin
          state_next = SCAN;
          load       = 1'b1;
        end
      end
      SCAN: begin
        if (!en)            state_next = IDLE;
        else if (frame_end) load       = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    // Dropping en darkens the pins on the very edge that leaves SCAN.
    lit = (state == SCAN) && en && (presc >= PRESC_BLANK) && sh_mask[idx];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc   <= '0;
      idx     <= '0;
      sh_dp   <= '0;
      sh_mask <= '0;
      tick_q  <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) sh_data[i] <= 4'h0;
    end else begin
      tick_q <= load;
      if (load) begin
        for (int i = 0; i < NUM_DIGITS; i++) sh_data[i] <= bus.data[4*i +: 4];
        sh_dp   <= bus.dp_in;
        sh_mask <= load_mask;
      end
      if (state != SCAN || state_next != SCAN) begin
        presc <= '0;
        idx   <= '0;
      end else if (slot_end) begin
        presc <= '0;
        idx   <= frame_end ? '0 : idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !lit) begin
      seg_q <= 7'b1111111;
      dp_q  <= 1'b1;
      an_q  <= '1;
    end else begin
      seg_q <= glyph(sh_data[idx]);
      dp_q  <= ~sh_dp[idx];
      an_q  <= ~(NUM_DIGITS'(1) << idx);
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// tb_seg7_scan_driver: random stimulus scored cycle-by-cycle against a frame-level display model.
// Revision: 1.0
module tb_seg7_scan_driver;
  localparam int N     = 4;
  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int FRAME = N * DIV;
  localparam logic [6:0] GLYPH [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b0011000,
    7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};

  typedef struct packed {
    logic [6:0]   seg;
    logic         dp;
    logic [N-1:0] an;
    logic         ft;
  } pins_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  seg7_if #(.NUM_DIGITS(N)) bus ();

  seg7_scan_driver #(
    .NUM_DIGITS  (N),
    .SCAN_DIV    (DIV),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  pins_t        exp_q[$];
  bit           scanning = 1'b0;
  int unsigned  pos = 0;
  logic [3:0]   s_data [N];
  logic [N-1:0] s_dp;
  logic [N-1:0] s_mask;

  function automatic pins_t dark();
    pins_t e;
    e.seg = 7'b1111111;
    e.dp  = 1'b1;
    e.an  = '1;
    e.ft  = 1'b0;
    return e;
  endfunction

  task automatic take_snapshot();
    int hi;
    hi = 0;
    for (int i = 0; i < N; i++) s_data[i] = bus.data[4*i +: 4];
    s_dp   = bus.dp_in;
    s_mask = bus.digit_mask;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    for (int i = 0; i < N; i++) if (s_data[i] != 4'h0 || s_dp[i]) hi = i;
    for (int i = 0; i < N; i++) if (i > hi) s_mask[i] = 1'b0;
`endif
  endtask

  // What the pins show for the p-th cycle after a frame load, given the snapshot in force.
  function automatic pins_t shown(input int unsigned p);
    pins_t e;
    int    d;
    int    off;
    e   = dark();
    d   = (p / DIV) % N;
    off = p % DIV;
    if (off >= BLANK && s_mask[d]) begin
      e.seg   = GLYPH[s_data[d]];
      e.dp    = ~s_dp[d];
      e.an[d] = 1'b0;
    end
    return e;
  endfunction

  initial forever begin
    pins_t e;
    @(posedge clk);
    e = dark();
    if (!rst_n) begin
      scanning = 1'b0;
    end else if (!scanning) begin
      if (bus.en) begin
        scanning = 1'b1;
        pos      = 0;
        take_snapshot();
        e.ft = 1'b1;
      end
    end else if (!bus.en) begin
      scanning = 1'b0;
    end else begin
      e = shown(pos);
      pos++;
      if (pos % FRAME == 0) begin
        take_snapshot();
        e.ft = 1'b1;
      end
    end
    exp_q.push_back(e);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  initial forever begin
    pins_t e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("seg", 32'(bus.seg), 32'(e.seg));
      check("dp", 32'(bus.dp), 32'(e.dp));
      check("an", 32'(bus.an), 32'(e.an));
      check("frame_tick", 32'(bus.frame_tick), 32'(e.ft));
      check("an_onehot", 32'($countones(~bus.an) <= 1), 32'd1);
    end
  end

  initial begin
    bus.en         = 1'b1;
    bus.data       = 16'h3210;
    bus.dp_in      = '0;
    bus.digit_mask = 4'hF;
    rst_n          = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    for (int v = 0; v < 16; v++) begin
      bus.data = {12'h000, 4'(v)};
      repeat (FRAME) @(negedge clk);
    end

    bus.data = 16'h1111;
    repeat (FRAME + 6) @(negedge clk);
    bus.data = 16'h2222;
    repeat (2 * FRAME) @(negedge clk);

    bus.digit_mask = 4'b0101;
    bus.dp_in      = 4'b0001;
    repeat (2 * FRAME + 6) @(negedge clk);
    bus.en = 1'b0;
    repeat (3) @(negedge clk);
    bus.en = 1'b1;
    repeat (2 * FRAME) @(negedge clk);

    bus.data       = 16'h0050;
    bus.dp_in      = '0;
    bus.digit_mask = 4'hF;
    repeat (2 * FRAME + 1) @(negedge clk);
    bus.dp_in = 4'b1000;
    repeat (2 * FRAME + 1) @(negedge clk);

    for (int k = 0; k < 80; k++) begin
      bus.data       = 16'($urandom);
      bus.dp_in      = N'($urandom);
      bus.digit_mask = N'($urandom);
      if ($urandom_range(0, 4) == 0) bus.en = ~bus.en;
      if ($urandom_range(0, 9) == 0) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      repeat ($urandom_range(1, 30)) @(negedge clk);
    end

    bus.en = 1'b1;
    repeat (FRAME) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
